// File: rtl/fft256_ctrl.sv
// Purpose : frame sequencer for a 256-point in-place radix-2 DIT FFT (load, 8 compute stages, drain).
// Latency : last input sample at T -> first butterfly issue at T+1, first valid_out at T+1+8*(128+BF_LAT)+RD_LAT.
// Backpr. : no output backpressure; input samples arriving while ready_in is low are dropped.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   valid_in, sop_in, inv_in    input sample framing; inv_in is captured with each accepted sop
//   ready_in                    high while idle or loading
//   load_en, load_addr          sample RAM write strobe and bit-reversed write address
//   bf_en, bf_addr_a/b, tw_idx  butterfly read issue, pair addresses, twiddle index
//   stage, inv_out              current stage, frame direction (conjugate twiddles when 1)
//   wb_en, wb_addr_a/b          butterfly issue delayed by BF_LAT (writeback)
//   rd_en, rd_addr              natural-order drain read issue
//   valid_out, sop_out          drain read delayed by RD_LAT; sop_out marks address 0
//   busy, err_sop               not idle; one-cycle pulse when sop arrives mid-frame
module fft256_ctrl #(
    parameter int BF_LAT = 3,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       sop_in,
    input  logic       inv_in,
    output logic       ready_in,
    output logic       load_en,
    output logic [7:0] load_addr,
    output logic       bf_en,
    output logic [7:0] bf_addr_a,
    output logic [7:0] bf_addr_b,
    output logic [6:0] tw_idx,
    output logic [2:0] stage,
    output logic       inv_out,
    output logic       wb_en,
    output logic [7:0] wb_addr_a,
    output logic [7:0] wb_addr_b,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    output logic       valid_out,
    output logic       sop_out,
    output logic       busy,
    output logic       err_sop
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // One stage = 128 issue cycles followed by BF_LAT idle cycles so the
    // last writeback of a stage lands before the next stage reads it.
    localparam int STAGE_CYC = 128 + BF_LAT;
    localparam int SW        = $clog2(STAGE_CYC);
    localparam logic [SW-1:0] STEP_LAST = SW'(STAGE_CYC - 1);
    localparam logic [SW-1:0] ISSUE_N   = SW'(128);

    typedef struct packed {
        logic       en;
        logic [7:0] a;
        logic [7:0] b;
    } bf_cmd_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [SW-1:0]  step_q, step_d;
    logic [2:0]     stage_q, stage_d;
    logic [7:0]     drn_q, drn_d;
    logic           inv_q, inv_d;

    bf_cmd_t        wb_q [BF_LAT];
    bf_cmd_t        wb_d [BF_LAT];
    logic [RD_LAT-1:0] vo_q, vo_d;
    logic [RD_LAT-1:0] so_q, so_d;

    logic [7:0]     cnt_rev;
    logic [7:0]     k8;
    logic [7:0]     span;
    logic [7:0]     pos;
    logic [3:0]     s_p1;
    logic [2:0]     tw_sh;
    logic [7:0]     a_raw;

    // Bit-reversed sample index gives the DIT input ordering.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_rev[i] = cnt_q[7-i];
        end
    end

    // Butterfly pair addressing for butterfly k of the current stage.
    // s_p1 is 4 bits wide so that stage 7 shifts by 8 rather than wrapping to 0.
    always_comb begin
        k8    = {1'b0, step_q[6:0]};
        span  = 8'd1 << stage_q;
        pos   = k8 & (span - 8'd1);
        s_p1  = {1'b0, stage_q} + 4'd1;
        tw_sh = 3'd7 - stage_q;
        a_raw = ((k8 >> stage_q) << s_p1) | pos;
    end

    // Next-state and control outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        stage_d   = stage_q;
        drn_d     = drn_q;
        inv_d     = inv_q;
        ready_in  = 1'b0;
        load_en   = 1'b0;
        load_addr = 8'd0;
        err_sop   = 1'b0;
        bf_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = 8'd0;

        case (state_q)
            S_IDLE: begin
                ready_in = 1'b1;
                if (valid_in && sop_in) begin
                    load_en = 1'b1;
                    inv_d   = inv_in;
                    cnt_d   = 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    load_en = 1'b1;
                    if (sop_in) begin
                        // Restart the frame: this sample becomes sample 0.
                        err_sop = 1'b1;
                        inv_d   = inv_in;
                        cnt_d   = 8'd1;
                    end else begin
                        load_addr = cnt_rev;
                        cnt_d     = cnt_q + 8'd1;
                        if (cnt_q == 8'hFF) begin
                            state_d = S_COMPUTE;
                            step_d  = '0;
                            stage_d = 3'd0;
                        end
                    end
                end
            end
            S_COMPUTE: begin
                bf_en = (step_q < ISSUE_N);
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (stage_q == 3'd7) begin
                        state_d = S_DRAIN;
                        drn_d   = 8'd0;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DRAIN: begin
                rd_en   = 1'b1;
                rd_addr = drn_q;
                drn_d   = drn_q + 8'd1;
                if (drn_q == 8'hFF) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address/twiddle outputs are forced to zero when no butterfly is issued.
    always_comb begin
        bf_addr_a = bf_en ? a_raw : 8'd0;
        bf_addr_b = bf_en ? (a_raw + span) : 8'd0;
        tw_idx    = bf_en ? 7'(pos << tw_sh) : 7'd0;
    end

    // Writeback and output-valid delay lines.
    always_comb begin
        wb_d[0].en = bf_en;
        wb_d[0].a  = bf_addr_a;
        wb_d[0].b  = bf_addr_b;
        for (int i = 1; i < BF_LAT; i++) begin
            wb_d[i] = wb_q[i-1];
        end
        vo_d    = vo_q;
        so_d    = so_q;
        vo_d[0] = rd_en;
        so_d[0] = rd_en && (drn_q == 8'd0);
        for (int i = 1; i < RD_LAT; i++) begin
            vo_d[i] = vo_q[i-1];
            so_d[i] = so_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            step_q  <= '0;
            stage_q <= 3'd0;
            drn_q   <= 8'd0;
            inv_q   <= 1'b0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_q[i] <= '0;
            end
            vo_q    <= '0;
            so_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            stage_q <= stage_d;
            drn_q   <= drn_d;
            inv_q   <= inv_d;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_q[i] <= wb_d[i];
            end
            vo_q    <= vo_d;
            so_q    <= so_d;
        end
    end

    assign stage     = stage_q;
    assign inv_out   = inv_q;
    assign busy      = (state_q != S_IDLE);
    assign wb_en     = wb_q[BF_LAT-1].en;
    assign wb_addr_a = wb_q[BF_LAT-1].a;
    assign wb_addr_b = wb_q[BF_LAT-1].b;
    assign valid_out = vo_q[RD_LAT-1];
    assign sop_out   = so_q[RD_LAT-1];

endmodule

// File: tb/tb_fft256_ctrl.sv
// Purpose : directed-sequence bench for fft256_ctrl with randomized input timing.
// Latency : expected outputs are derived per cycle from the frame schedule.
// Backpr. : none; inputs are driven freely, including while the DUT is not ready.
module tb_fft256_ctrl;

    localparam int BF_LAT = 3;
    localparam int RD_LAT = 1;
    localparam int P      = 128 + BF_LAT;
    localparam int FULL   = 8 * P + 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       sop_in = 1'b0;
    logic       inv_in = 1'b0;
    logic       ready_in, load_en, bf_en, inv_out, wb_en, rd_en, valid_out, sop_out, busy, err_sop;
    logic [7:0] load_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr;
    logic [6:0] tw_idx;
    logic [2:0] stage;

    fft256_ctrl #(.BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in), .inv_in(inv_in),
        .ready_in(ready_in), .load_en(load_en), .load_addr(load_addr),
        .bf_en(bf_en), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .tw_idx(tw_idx),
        .stage(stage), .inv_out(inv_out), .wb_en(wb_en), .wb_addr_a(wb_addr_a),
        .wb_addr_b(wb_addr_b), .rd_en(rd_en), .rd_addr(rd_addr), .valid_out(valid_out),
        .sop_out(sop_out), .busy(busy), .err_sop(err_sop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference tables: butterfly list in stage/group/leg order, bit-reverse table.
    int ref_a  [1024];
    int ref_b  [1024];
    int ref_tw [1024];
    int ref_rev[256];

    // Tracked observable state carried between phases.
    int exp_stage = 0;
    bit exp_inv   = 1'b0;
    int pend_vo   = 0;

    typedef struct {
        bit bf;  int a;  int b;  int tw; int st;
        bit wb;  int wa; int wbv;
        bit rd;  int ra;
        bit vo;  bit so;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void build_refs();
        for (int i = 0; i < 256; i++) begin
            int x = i;
            int r = 0;
            for (int j = 0; j < 8; j++) begin
                r = r * 2 + (x % 2);
                x = x / 2;
            end
            ref_rev[i] = r;
        end
        for (int s = 0; s < 8; s++) begin
            int span = 1 << s;
            for (int g = 0; g < 128 / span; g++) begin
                for (int j = 0; j < span; j++) begin
                    int idx = s * 128 + g * span + j;
                    ref_a[idx]  = g * 2 * span + j;
                    ref_b[idx]  = g * 2 * span + j + span;
                    ref_tw[idx] = j * (128 / span);
                end
            end
        end
    endfunction

    // Index into the butterfly list for compute-phase cycle n, or -1 when idle.
    function automatic int bf_idx(input int n);
        if (n < 0 || n >= 8 * P) return -1;
        if ((n % P) >= 128) return -1;
        return (n / P) * 128 + (n % P);
    endfunction

    function automatic exp_t sched(input int n);
        exp_t e;
        int idx, m, mv;
        idx = bf_idx(n);
        e.bf = (idx >= 0);
        e.a  = e.bf ? ref_a[idx]  : 0;
        e.b  = e.bf ? ref_b[idx]  : 0;
        e.tw = e.bf ? ref_tw[idx] : 0;
        e.st = (n < 8 * P) ? n / P : 7;
        m    = bf_idx(n - BF_LAT);
        e.wb = (m >= 0);
        e.wa = e.wb ? ref_a[m] : 0;
        e.wbv = e.wb ? ref_b[m] : 0;
        e.rd = (n >= 8 * P) && (n < 8 * P + 256);
        e.ra = n - 8 * P;
        mv   = n - RD_LAT;
        e.vo = (mv >= 8 * P) && (mv < 8 * P + 256);
        e.so = (mv == 8 * P);
        return e;
    endfunction

    task automatic idle_cycles(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
            sop_in   = 1'($urandom_range(0, 1));
            inv_in   = 1'($urandom_range(0, 1));
            #1;
            chk("idle_ready", ready_in, 1);
            chk("idle_busy", busy, 0);
            chk("idle_load_en", load_en, 0);
            chk("idle_err_sop", err_sop, 0);
            chk("idle_bf_en", bf_en, 0);
            chk("idle_wb_en", wb_en, 0);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_valid_out", valid_out, (pend_vo > 0) ? 1 : 0);
            chk("idle_sop_out", sop_out, 0);
            chk("idle_stage", stage, exp_stage);
            chk("idle_inv_out", inv_out, exp_inv);
            if (pend_vo > 0) pend_vo--;
        end
    endtask

    // mode 0: contiguous, 1: every 3rd cycle, 2: random gaps (with a leading
    // valid-without-sop that must be ignored). err_at >= 0 injects a sop once
    // that many samples have been accepted.
    task automatic load_frame(input int mode, input bit finv, input int err_at);
        int acc = 0;
        int cyc = 0;
        bit started = 1'b0;
        bit err_done = 1'b0;
        bit lead_nosop = (mode == 2);
        bit v, s, sinv, accept;
        while (acc < 256) begin
            if (cyc >= 6000) begin
                chk("load_timeout", acc, 256);
                break;
            end
            @(negedge clk);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = ((cyc % 3) == 0);
            else                v = ($urandom_range(0, 2) == 0);
            if (v && lead_nosop) begin
                s = 1'b0;
                lead_nosop = 1'b0;
            end else begin
                s = v && (!started || (acc == err_at && !err_done));
            end
            sinv     = finv ^ started;
            valid_in = v;
            sop_in   = v ? s : 1'($urandom_range(0, 1));
            inv_in   = (v && s) ? sinv : 1'($urandom_range(0, 1));
            #1;
            accept = v && (started || s);
            chk("load_en", load_en, accept);
            if (accept) chk("load_addr", load_addr, s ? 0 : ref_rev[acc]);
            chk("load_err_sop", err_sop, (v && s && started) ? 1 : 0);
            chk("load_ready", ready_in, 1);
            chk("load_busy", busy, started);
            chk("load_inv_out", inv_out, exp_inv);
            chk("load_bf_en", bf_en, 0);
            chk("load_rd_en", rd_en, 0);
            chk("load_wb_en", wb_en, 0);
            chk("load_valid_out", valid_out, (pend_vo > 0) ? 1 : 0);
            chk("load_sop_out", sop_out, 0);
            chk("load_stage", stage, exp_stage);
            if (pend_vo > 0) pend_vo--;
            if (accept) begin
                if (s) begin
                    if (started) err_done = 1'b1;
                    started = 1'b1;
                    acc     = 1;
                    exp_inv = sinv;
                end else begin
                    acc++;
                end
            end
            cyc++;
        end
    endtask

    // Compute + drain phase; cycle n = 0 is the cycle after the last accepted sample.
    task automatic run_compute(input int stop_n);
        exp_t e;
        for (int n = 0; n < stop_n; n++) begin
            @(negedge clk);
            valid_in = 1'($urandom_range(0, 1));
            sop_in   = 1'($urandom_range(0, 1));
            inv_in   = 1'($urandom_range(0, 1));
            #1;
            e = sched(n);
            chk("cmp_ready", ready_in, 0);
            chk("cmp_load_en", load_en, 0);
            chk("cmp_err_sop", err_sop, 0);
            chk("cmp_busy", busy, 1);
            chk("cmp_inv_out", inv_out, exp_inv);
            chk("bf_en", bf_en, e.bf);
            if (e.bf) begin
                chk("bf_addr_a", bf_addr_a, e.a);
                chk("bf_addr_b", bf_addr_b, e.b);
                chk("tw_idx", tw_idx, e.tw);
            end
            chk("stage", stage, e.st);
            chk("wb_en", wb_en, e.wb);
            if (e.wb) begin
                chk("wb_addr_a", wb_addr_a, e.wa);
                chk("wb_addr_b", wb_addr_b, e.wbv);
            end
            chk("rd_en", rd_en, e.rd);
            if (e.rd) chk("rd_addr", rd_addr, e.ra);
            chk("valid_out", valid_out, e.vo);
            chk("sop_out", sop_out, e.so);
        end
        if (stop_n == FULL) begin
            exp_stage = 7;
            pend_vo   = RD_LAT;
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        inv_in   = 1'b0;
        repeat (ncyc - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", ready_in, 1);
        chk("rst_busy", busy, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_err_sop", err_sop, 0);
        chk("rst_bf_en", bf_en, 0);
        chk("rst_bf_addr_a", bf_addr_a, 0);
        chk("rst_bf_addr_b", bf_addr_b, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_stage", stage, 0);
        chk("rst_inv_out", inv_out, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_addr_a", wb_addr_a, 0);
        chk("rst_wb_addr_b", wb_addr_b, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_sop_out", sop_out, 0);
        exp_stage = 0;
        exp_inv   = 1'b0;
        pend_vo   = 0;
    endtask

    initial begin
        build_refs();

        // Power-on reset and idle behaviour.
        do_reset(3);
        idle_cycles(4);

        // Frame A: contiguous input, inverse transform, full compute and drain.
        load_frame(0, 1'b1, -1);
        run_compute(FULL);

        // Frame B starts the cycle after the last drain read: sparse input,
        // mid-frame sop at sample 100 with a different inv, then reset in stage 4.
        load_frame(1, 1'b0, 100);
        run_compute(4 * P + 50);
        do_reset(2);
        idle_cycles(BF_LAT + 3);

        // Frame C: random gaps, random direction, completes normally.
        load_frame(2, 1'($urandom_range(0, 1)), -1);
        run_compute(FULL);
        idle_cycles(RD_LAT + 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
